// File: rtl/lsu_align_unit.sv
// Load/store byte-lane alignment unit: lane masks, store-data shifting, load merge/extension.
// Optional: define LSU_MISALIGNED_SPLIT_EN to allow misaligned accesses (split across two beats).

package lsu_align_pkg;
  typedef enum logic [3:0] {
    memop_none = 4'd0,
    l_byte     = 4'd1,
    l_hword    = 4'd2,
    l_word     = 4'd3,
    l_ubyte    = 4'd4,
    l_uhword   = 4'd5,
    s_byte     = 4'd6,
    s_hword    = 4'd7,
    s_word     = 4'd8
  } rv32_memop;
endpackage

module lsu_align_unit
  import lsu_align_pkg::*;
#(
  parameter int BUS_BYTES = 4,
  parameter int ADDR_W    = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [ADDR_W-1:0]      i_req_addr,
  input  rv32_memop              i_req_memop,
  input  logic [31:0]            i_req_wdata,
  output logic                   o_bus_valid,
  input  logic                   i_bus_ready,
  output logic [ADDR_W-1:0]      o_bus_addr,
  output logic                   o_bus_we,
  output logic [BUS_BYTES-1:0]   o_bus_mask,
  output logic [8*BUS_BYTES-1:0] o_bus_wdata,
  input  logic                   i_bus_ack,
  input  logic [8*BUS_BYTES-1:0] i_bus_rdata,
  output logic                   o_rsp_valid,
  output logic [31:0]            o_rsp_rdata,
  output logic                   o_rsp_error
);

  localparam int OFF_W = $clog2(BUS_BYTES);
  localparam int BW    = 8 * BUS_BYTES;

  typedef enum logic [2:0] {IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP} state_t;

  state_t                 state_q;
  logic                   req_ready_q;
  logic [ADDR_W-1:0]      base_addr_q;
  logic [OFF_W-1:0]       off_q;
  rv32_memop              memop_q;
  logic                   store_q;
  logic                   split_q;
  logic [BUS_BYTES-1:0]   mask_hi_q;
  logic [BW-1:0]          wdata_hi_q;
  logic [BW-1:0]          rdata0_q;
  logic                   bus_valid_q;
  logic [ADDR_W-1:0]      bus_addr_q;
  logic                   bus_we_q;
  logic [BUS_BYTES-1:0]   bus_mask_q;
  logic [BW-1:0]          bus_wdata_q;
  logic                   rsp_valid_q;
  logic [31:0]            rsp_rdata_q;
  logic                   rsp_error_q;

  logic                   req_load;
  logic                   req_store;
  logic [2:0]             req_size;
  logic [3:0]             size_mask;
  logic                   req_misaligned;
  logic                   req_error;
  logic [OFF_W-1:0]       req_off;
  logic [ADDR_W-1:0]      req_base;
  logic [2*BUS_BYTES-1:0] req_mask;
  logic [2*BW-1:0]        req_wdata_wide;
  logic                   ack0;
  logic                   ack1;
  logic                   second_beat;
  logic [2*BW-1:0]        load_src;
  logic [31:0]            load_word;
  logic [31:0]            load_ext_d;

  always_comb begin
    req_load  = 1'b0;
    req_store = 1'b0;
    req_size  = 3'd0;
    case (i_req_memop)
      l_byte, l_ubyte:   begin req_load  = 1'b1; req_size = 3'd1; end
      l_hword, l_uhword: begin req_load  = 1'b1; req_size = 3'd2; end
      l_word:            begin req_load  = 1'b1; req_size = 3'd4; end
      s_byte:            begin req_store = 1'b1; req_size = 3'd1; end
      s_hword:           begin req_store = 1'b1; req_size = 3'd2; end
      s_word:            begin req_store = 1'b1; req_size = 3'd4; end
      default:           ;
    endcase
  end

  always_comb begin
    case (req_size)
      3'd1:    size_mask = 4'b0001;
      3'd2:    size_mask = 4'b0011;
      3'd4:    size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  end

  assign req_off        = i_req_addr[OFF_W-1:0];
  assign req_base       = {i_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign req_misaligned = ((req_size == 3'd2) && i_req_addr[0]) ||
                          ((req_size == 3'd4) && (i_req_addr[1:0] != 2'b00));

  // Both halves are always built; the high half only becomes nonzero for
  // bus-boundary crossings, which the non-split build rejects as misaligned.
  assign req_mask       = {{(2*BUS_BYTES-4){1'b0}}, size_mask} << req_off;
  assign req_wdata_wide = {{(2*BW-32){1'b0}}, i_req_wdata} << {req_off, 3'b000};

`ifdef LSU_MISALIGNED_SPLIT_EN
  assign req_error = !(req_load || req_store);
`else
  assign req_error = !(req_load || req_store) || req_misaligned;
`endif

  assign ack0        = i_bus_ack && (((state_q == BEAT0) && i_bus_ready) || (state_q == WAIT0));
  assign ack1        = i_bus_ack && (((state_q == BEAT1) && i_bus_ready) || (state_q == WAIT1));
  assign second_beat = (state_q == BEAT1) || (state_q == WAIT1);

  // The final beat's data comes straight from the bus; only beat 0 is buffered.
  assign load_src  = second_beat ? {i_bus_rdata, rdata0_q} : {{BW{1'b0}}, i_bus_rdata};
  assign load_word = 32'(load_src >> {off_q, 3'b000});

  always_comb begin
    case (memop_q)
      l_byte:   load_ext_d = {{24{load_word[7]}}, load_word[7:0]};
      l_ubyte:  load_ext_d = {24'd0, load_word[7:0]};
      l_hword:  load_ext_d = {{16{load_word[15]}}, load_word[15:0]};
      l_uhword: load_ext_d = {16'd0, load_word[15:0]};
      l_word:   load_ext_d = load_word;
      default:  load_ext_d = 32'd0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      base_addr_q <= '0;
      off_q       <= '0;
      memop_q     <= memop_none;
      store_q     <= 1'b0;
      split_q     <= 1'b0;
      mask_hi_q   <= '0;
      wdata_hi_q  <= '0;
      rdata0_q    <= '0;
      bus_valid_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_mask_q  <= '0;
      bus_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (i_req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            base_addr_q <= req_base;
            off_q       <= req_off;
            memop_q     <= i_req_memop;
            store_q     <= req_store;
            split_q     <= |req_mask[2*BUS_BYTES-1:BUS_BYTES];
            mask_hi_q   <= req_mask[2*BUS_BYTES-1:BUS_BYTES];
            wdata_hi_q  <= req_wdata_wide[2*BW-1:BW];
            if (req_error) begin
              rsp_valid_q <= 1'b1;
              rsp_error_q <= 1'b1;
              rsp_rdata_q <= 32'd0;
              state_q     <= RESP;
            end else begin
              bus_valid_q <= 1'b1;
              bus_addr_q  <= req_base;
              bus_we_q    <= req_store;
              bus_mask_q  <= req_mask[BUS_BYTES-1:0];
              bus_wdata_q <= req_wdata_wide[BW-1:0];
              state_q     <= BEAT0;
            end
          end
        end
        BEAT0, BEAT1: begin
          if (i_bus_ready) begin
            bus_valid_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_we_q    <= 1'b0;
            bus_mask_q  <= '0;
            bus_wdata_q <= '0;
            state_q     <= (state_q == BEAT0) ? WAIT0 : WAIT1;
          end
        end
        WAIT0, WAIT1: ;
        RESP: begin
          req_ready_q <= 1'b1;
          rsp_error_q <= 1'b0;
          rsp_rdata_q <= 32'd0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Acks override the beat-acceptance defaults above when they coincide.
      if (ack0) begin
        rdata0_q <= i_bus_rdata;
        if (split_q) begin
          bus_valid_q <= 1'b1;
          bus_addr_q  <= base_addr_q + ADDR_W'(BUS_BYTES);
          bus_we_q    <= store_q;
          bus_mask_q  <= mask_hi_q;
          bus_wdata_q <= wdata_hi_q;
          state_q     <= BEAT1;
        end else begin
          rsp_valid_q <= 1'b1;
          rsp_error_q <= 1'b0;
          rsp_rdata_q <= load_ext_d;
          state_q     <= RESP;
        end
      end
      if (ack1) begin
        rsp_valid_q <= 1'b1;
        rsp_error_q <= 1'b0;
        rsp_rdata_q <= load_ext_d;
        state_q     <= RESP;
      end
    end
  end

  assign o_req_ready = req_ready_q;
  assign o_bus_valid = bus_valid_q;
  assign o_bus_addr  = bus_addr_q;
  assign o_bus_we    = bus_we_q;
  assign o_bus_mask  = bus_mask_q;
  assign o_bus_wdata = bus_wdata_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_error = rsp_error_q;

endmodule

// File: tb/tb_lsu_align_unit.sv
// Directed bench for lsu_align_unit: a 4-byte-bus instance and an 8-byte-bus instance.
module tb_lsu_align_unit;
  import lsu_align_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  rv32_memop   req_memop;
  logic        bus_valid, bus_ready, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_mask;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;

  logic        req_valid_w, req_ready_w;
  logic [31:0] req_addr_w, req_wdata_w;
  rv32_memop   req_memop_w;
  logic        bus_valid_w, bus_ready_w, bus_we_w, bus_ack_w;
  logic [31:0] bus_addr_w;
  logic [63:0] bus_wdata_w, bus_rdata_w;
  logic [7:0]  bus_mask_w;
  logic        rsp_valid_w, rsp_error_w;
  logic [31:0] rsp_rdata_w;

  int checks = 0;
  int errors = 0;

  lsu_align_unit #(.BUS_BYTES(4), .ADDR_W(32)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
    .i_req_memop(req_memop), .i_req_wdata(req_wdata),
    .o_bus_valid(bus_valid), .i_bus_ready(bus_ready), .o_bus_addr(bus_addr),
    .o_bus_we(bus_we), .o_bus_mask(bus_mask), .o_bus_wdata(bus_wdata),
    .i_bus_ack(bus_ack), .i_bus_rdata(bus_rdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_error(rsp_error)
  );

  lsu_align_unit #(.BUS_BYTES(8), .ADDR_W(32)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid_w), .o_req_ready(req_ready_w), .i_req_addr(req_addr_w),
    .i_req_memop(req_memop_w), .i_req_wdata(req_wdata_w),
    .o_bus_valid(bus_valid_w), .i_bus_ready(bus_ready_w), .o_bus_addr(bus_addr_w),
    .o_bus_we(bus_we_w), .o_bus_mask(bus_mask_w), .o_bus_wdata(bus_wdata_w),
    .i_bus_ack(bus_ack_w), .i_bus_rdata(bus_rdata_w),
    .o_rsp_valid(rsp_valid_w), .o_rsp_rdata(rsp_rdata_w), .o_rsp_error(rsp_error_w)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input rv32_memop op, input logic [31:0] wd);
    req_valid = 1'b1;
    req_addr  = a;
    req_memop = op;
    req_wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_memop = memop_none; req_wdata = '0;
    bus_ready = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    req_valid_w = 1'b0; req_addr_w = '0; req_memop_w = memop_none; req_wdata_w = '0;
    bus_ready_w = 1'b0; bus_ack_w = 1'b0; bus_rdata_w = '0;
    repeat (3) tick();

    check("rst_ready", req_ready, 0);
    check("rst_bus_valid", bus_valid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_bus_mask", bus_mask, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    rst_n = 1'b1;
    tick();
    check("idle_ready", req_ready, 1);

    // sw, aligned, ack one cycle after acceptance
    bus_ready = 1'b1;
    issue(32'h1000, s_word, 32'hAABBCCDD);
    check("sw_bus_valid", bus_valid, 1);
    check("sw_bus_addr", bus_addr, 32'h1000);
    check("sw_bus_mask", bus_mask, 4'b1111);
    check("sw_bus_wdata", bus_wdata, 32'hAABBCCDD);
    check("sw_bus_we", bus_we, 1);
    check("sw_busy_ready", req_ready, 0);
    tick();
    check("sw_wait_valid", bus_valid, 0);
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    tick();
    bus_ack = 1'b0;
    check("sw_rsp_valid", rsp_valid, 1);
    check("sw_rsp_error", rsp_error, 0);
    check("sw_rsp_rdata", rsp_rdata, 0);
    tick();
    check("sw_rsp_pulse", rsp_valid, 0);
    check("sw_back_ready", req_ready, 1);

    // lbu with ack in the acceptance cycle
    issue(32'h3001, l_ubyte, 32'h0);
    check("lbu_bus_addr", bus_addr, 32'h3000);
    check("lbu_bus_mask", bus_mask, 4'b0010);
    check("lbu_bus_we", bus_we, 0);
    bus_ack = 1'b1; bus_rdata = 32'h0000A500;
    tick();
    bus_ack = 1'b0;
    check("lbu_rsp_valid", rsp_valid, 1);
    check("lbu_rsp_rdata", rsp_rdata, 32'h000000A5);
    tick();

    // lb with a stalled bus: beat must hold until ready
    bus_ready = 1'b0;
    issue(32'h3001, l_byte, 32'h0);
    check("lb_bus_valid", bus_valid, 1);
    tick();
    check("lb_hold_valid", bus_valid, 1);
    check("lb_hold_mask", bus_mask, 4'b0010);
    check("lb_hold_addr", bus_addr, 32'h3000);
    bus_ready = 1'b1;
    tick();
    check("lb_wait_valid", bus_valid, 0);
    check("lb_wait_no_rsp", rsp_valid, 0);
    bus_ack = 1'b1; bus_rdata = 32'h00008000;
    tick();
    bus_ack = 1'b0;
    check("lb_rsp_valid", rsp_valid, 1);
    check("lb_rsp_rdata", rsp_rdata, 32'hFFFFFF80);
    tick();

    // halfword zero- and sign-extension
    issue(32'h2002, l_uhword, 32'h0);
    check("lhu_bus_mask", bus_mask, 4'b1100);
    bus_ack = 1'b1; bus_rdata = 32'h80010000;
    tick();
    bus_ack = 1'b0;
    check("lhu_rsp_rdata", rsp_rdata, 32'h00008001);
    tick();
    issue(32'h2002, l_hword, 32'h0);
    bus_ack = 1'b1; bus_rdata = 32'h80010000;
    tick();
    bus_ack = 1'b0;
    check("lh_rsp_rdata", rsp_rdata, 32'hFFFF8001);
    tick();

    // sb to the top lane: only the low byte of wdata lands
    issue(32'h1003, s_byte, 32'h123456EE);
    check("sb_bus_mask", bus_mask, 4'b1000);
    check("sb_bus_wdata", bus_wdata, 32'hEE000000);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    check("sb_rsp_valid", rsp_valid, 1);
    tick();

`ifdef LSU_MISALIGNED_SPLIT_EN
    issue(32'h1002, s_word, 32'hAABBCCDD);
    check("ssw_b0_addr", bus_addr, 32'h1000);
    check("ssw_b0_mask", bus_mask, 4'b1100);
    check("ssw_b0_wdata", bus_wdata, 32'hCCDD0000);
    bus_ack = 1'b1;
    tick();
    check("ssw_b1_valid", bus_valid, 1);
    check("ssw_b1_addr", bus_addr, 32'h1004);
    check("ssw_b1_mask", bus_mask, 4'b0011);
    check("ssw_b1_wdata", bus_wdata, 32'h0000AABB);
    tick();
    bus_ack = 1'b0;
    check("ssw_rsp_valid", rsp_valid, 1);
    check("ssw_rsp_error", rsp_error, 0);
    tick();

    issue(32'h2003, l_hword, 32'h0);
    check("slh_b0_mask", bus_mask, 4'b1000);
    bus_ack = 1'b1; bus_rdata = 32'h11223344;
    tick();
    check("slh_b1_mask", bus_mask, 4'b0001);
    check("slh_b1_addr", bus_addr, 32'h2004);
    bus_rdata = 32'h556677F0;
    tick();
    bus_ack = 1'b0;
    check("slh_rsp_valid", rsp_valid, 1);
    check("slh_rsp_rdata", rsp_rdata, 32'hFFFFF011);
    tick();

    issue(32'hFFFFFFFE, l_word, 32'h0);
    check("wrap_b0_addr", bus_addr, 32'hFFFFFFFC);
    bus_ack = 1'b1; bus_rdata = 32'hBBAA0000;
    tick();
    check("wrap_b1_addr", bus_addr, 32'h00000000);
    bus_rdata = 32'h0000DDCC;
    tick();
    bus_ack = 1'b0;
    check("wrap_rsp_rdata", rsp_rdata, 32'hDDCCBBAA);
    tick();
`else
    issue(32'h1002, l_word, 32'h0);
    check("mis_rsp_valid", rsp_valid, 1);
    check("mis_rsp_error", rsp_error, 1);
    check("mis_bus_valid", bus_valid, 0);
    check("mis_rsp_rdata", rsp_rdata, 0);
    tick();
    check("mis_rsp_pulse", rsp_valid, 0);
    check("mis_bus_after", bus_valid, 0);
    check("mis_ready", req_ready, 1);
    issue(32'h1001, s_hword, 32'h1234);
    check("mis_sh_error", rsp_error, 1);
    check("mis_sh_bus", bus_valid, 0);
    tick();
`endif

    // invalid memops
    issue(32'h1000, memop_none, 32'h0);
    check("inv_rsp_valid", rsp_valid, 1);
    check("inv_rsp_error", rsp_error, 1);
    check("inv_bus_valid", bus_valid, 0);
    tick();
    issue(32'h1000, rv32_memop'(4'hF), 32'h0);
    check("inv2_rsp_error", rsp_error, 1);
    tick();
    check("inv2_error_clear", rsp_error, 0);

    // 8-byte bus: upper half lanes
    bus_ready_w = 1'b1;
    req_valid_w = 1'b1; req_addr_w = 32'h1004; req_memop_w = s_word; req_wdata_w = 32'h12345678;
    tick();
    req_valid_w = 1'b0;
    check("w8_sw_valid", bus_valid_w, 1);
    check("w8_sw_addr", bus_addr_w, 32'h1000);
    check("w8_sw_mask", bus_mask_w, 8'hF0);
    check("w8_sw_wdata", bus_wdata_w, 64'h12345678_00000000);
    bus_ack_w = 1'b1;
    tick();
    bus_ack_w = 1'b0;
    check("w8_sw_rsp", rsp_valid_w, 1);
    tick();
    req_valid_w = 1'b1; req_addr_w = 32'h1004; req_memop_w = l_word;
    tick();
    req_valid_w = 1'b0;
    bus_ack_w = 1'b1; bus_rdata_w = 64'h89ABCDEF_00000000;
    tick();
    bus_ack_w = 1'b0;
    check("w8_lw_rdata", rsp_rdata_w, 32'h89ABCDEF);
    tick();

    // reset while waiting for an ack abandons the access
    bus_ready = 1'b1;
    issue(32'h5000, l_word, 32'h0);
    tick();
    check("rmid_wait_valid", bus_valid, 0);
    rst_n = 1'b0;
    tick();
    check("rmid_ready", req_ready, 0);
    check("rmid_bus_valid", bus_valid, 0);
    check("rmid_bus_addr", bus_addr, 0);
    check("rmid_bus_mask", bus_mask, 0);
    check("rmid_rsp_valid", rsp_valid, 0);
    check("rmid_rsp_error", rsp_error, 0);
    rst_n = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    tick();
    bus_ack = 1'b0;
    check("rmid_stray_ack", rsp_valid, 0);
    tick();
    check("rmid_no_rsp", rsp_valid, 0);
    check("rmid_ready_back", req_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
